ucsbece154b_mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between pipeline fetch (IF) and load/store (MEM) requesters.

---
 rtl/ucsbece154b_mem_arbiter_pkg.sv | 13 +
 rtl/ucsbece154b_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_ucsbece154b_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ucsbece154b_mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory arbiter: FSM state encoding
// and the default fairness limit.
package ucsbece154b_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      arb_idle  = 2'd0,
      arb_fetch = 2'd1,
      arb_data  = 2'd2
   } arb_state_e;

   localparam int unsigned FAIR_LIMIT_DEF = 4;

endpackage

// File: rtl/ucsbece154b_mem_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and
// load/store, one outstanding req/ack transaction at a time, with fetch starvation guard.
module ucsbece154b_mem_arbiter
   import ucsbece154b_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FAIR_LIMIT = FAIR_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              if_flush_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_valid_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_fetch_o,
   output logic              stall_mem_o
);

   localparam int unsigned   CNT_W    = $clog2(FAIR_LIMIT + 1);
   localparam logic [CNT_W-1:0] FAIR_MAX = CNT_W'(FAIR_LIMIT);

   arb_state_e        state_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              if_valid_q;
   logic              dm_valid_q;
   logic              cancel_q;
   logic [CNT_W-1:0]  fair_cnt_q;

   // Arbitration FSM: grants, memory request sequencing, capture and valid pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= arb_idle;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         cancel_q    <= 1'b0;
         fair_cnt_q  <= '0;
      end else begin
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
         case (state_q)
            arb_idle: begin
               if (!if_req_i) begin
                  fair_cnt_q <= '0;
               end
               // Data wins unless a waiting fetch has been passed over FAIR_LIMIT times.
               if (dm_req_i && ((fair_cnt_q < FAIR_MAX) || !if_req_i)) begin
                  state_q     <= arb_data;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= dm_we_i;
                  mem_addr_q  <= dm_addr_i;
                  mem_wdata_q <= dm_wdata_i;
                  if (if_req_i && (fair_cnt_q != FAIR_MAX)) begin
                     fair_cnt_q <= fair_cnt_q + CNT_W'(1);
                  end
               end else if (if_req_i && !if_flush_i) begin
                  state_q    <= arb_fetch;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= if_addr_i;
                  fair_cnt_q <= '0;
               end
            end
            arb_fetch: begin
               if (mem_ack_i) begin
                  state_q   <= arb_idle;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  cancel_q  <= 1'b0;
                  // A redirect seen at any point of this fetch makes its data stale.
                  if (!(cancel_q || if_flush_i)) begin
                     if_rdata_q <= mem_rdata_i;
                     if_valid_q <= 1'b1;
                  end
               end else if (if_flush_i) begin
                  cancel_q <= 1'b1;
               end
            end
            arb_data: begin
               if (mem_ack_i) begin
                  state_q    <= arb_idle;
                  mem_req_q  <= 1'b0;
                  mem_we_q   <= 1'b0;
                  dm_valid_q <= 1'b1;
                  if (!mem_we_q) begin
                     dm_rdata_q <= mem_rdata_i;
                  end
               end
            end
            default: begin
               state_q   <= arb_idle;
               mem_req_q <= 1'b0;
               mem_we_q  <= 1'b0;
               cancel_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign if_valid_o  = if_valid_q;
   assign dm_valid_o  = dm_valid_q;

   // Stalls release in the valid cycle so the pipeline advances exactly once.
   assign stall_fetch_o = if_req_i & ~if_valid_q & ~if_flush_i;
   assign stall_mem_o   = dm_req_i & ~dm_valid_q;

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed bench for the IF/MEM memory arbiter with a small latency-configurable
// memory model whose read data is the address XOR a fixed key.
module tb_ucsbece154b_mem_arbiter;

   localparam logic [31:0] KEY = 32'h1234_5678;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req_i, if_flush_i, dm_req_i, dm_we_i;
   logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
   logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        if_valid_o, dm_valid_o, mem_req_o, mem_we_o, mem_ack_i;
   logic        stall_fetch_o, stall_mem_o;

   int unsigned lat;
   int unsigned wait_cnt;
   logic        model_en;
   logic        ack_force;
   int          vec;
   int          err;

   ucsbece154b_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
      .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .stall_fetch_o(stall_fetch_o), .stall_mem_o(stall_mem_o)
   );

   always #5 clk = ~clk;

   // Memory model: ack once the request has been held for lat extra cycles.
   assign mem_ack_i   = ack_force | (model_en & mem_req_o & (wait_cnt == lat));
   assign mem_rdata_i = mem_ack_i ? (mem_addr_o ^ KEY) : 32'h0;

   always @(posedge clk) begin
      if (!mem_req_o || mem_ack_i) wait_cnt <= 0;
      else                         wait_cnt <= wait_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vec++; if (mem_req_o !== 1'b0) begin err++; $display("FAIL rst_mem_req got=%b exp=0", mem_req_o); end
      vec++; if (mem_we_o !== 1'b0) begin err++; $display("FAIL rst_mem_we got=%b exp=0", mem_we_o); end
      vec++; if (if_valid_o !== 1'b0 || dm_valid_o !== 1'b0) begin err++; $display("FAIL rst_valids got=%b%b exp=00", if_valid_o, dm_valid_o); end
      vec++; if (mem_addr_o !== 32'h0 || if_rdata_o !== 32'h0 || dm_rdata_o !== 32'h0) begin err++; $display("FAIL rst_regs got=%h/%h/%h exp=0", mem_addr_o, if_rdata_o, dm_rdata_o); end
      reset = 1'b0;
   endtask

   task test_fetch_only();
      lat = 1; if_req_i = 1'b1; if_addr_i = 32'h10;
      #1;
      vec++; if (stall_fetch_o !== 1'b1) begin err++; $display("FAIL fetch_stall_on got=%b exp=1", stall_fetch_o); end
      @(negedge clk);
      vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10 || mem_we_o !== 1'b0) begin err++; $display("FAIL fetch_req got=%b/%h/%b exp=1/00000010/0", mem_req_o, mem_addr_o, mem_we_o); end
      @(negedge clk);
      vec++; if (if_valid_o !== 1'b0 || stall_fetch_o !== 1'b1 || mem_req_o !== 1'b1) begin err++; $display("FAIL fetch_wait got=%b/%b/%b exp=0/1/1", if_valid_o, stall_fetch_o, mem_req_o); end
      @(negedge clk);
      vec++; if (if_valid_o !== 1'b1) begin err++; $display("FAIL fetch_valid got=%b exp=1", if_valid_o); end
      vec++; if (if_rdata_o !== (32'h10 ^ KEY)) begin err++; $display("FAIL fetch_rdata got=%h exp=%h", if_rdata_o, 32'h10 ^ KEY); end
      vec++; if (stall_fetch_o !== 1'b0 || mem_req_o !== 1'b0) begin err++; $display("FAIL fetch_done got=%b/%b exp=0/0", stall_fetch_o, mem_req_o); end
      if_req_i = 1'b0;
      @(negedge clk);
      vec++; if (if_valid_o !== 1'b0 || if_rdata_o !== (32'h10 ^ KEY)) begin err++; $display("FAIL fetch_pulse_hold got=%b/%h exp=0/%h", if_valid_o, if_rdata_o, 32'h10 ^ KEY); end
   endtask

   task test_priority();
      lat = 1;
      if_req_i = 1'b1; if_addr_i = 32'h40;
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEAD;
      #1;
      vec++; if (stall_fetch_o !== 1'b1 || stall_mem_o !== 1'b1) begin err++; $display("FAIL prio_stalls got=%b%b exp=11", stall_fetch_o, stall_mem_o); end
      @(negedge clk);
      vec++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_wdata_o !== 32'hDEAD) begin err++; $display("FAIL prio_data_first got=%b/%b/%h/%h exp=1/1/00000200/0000dead", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
      @(negedge clk);
      vec++; if (stall_mem_o !== 1'b1 || dm_valid_o !== 1'b0) begin err++; $display("FAIL prio_store_wait got=%b/%b exp=1/0", stall_mem_o, dm_valid_o); end
      @(negedge clk);
      vec++; if (dm_valid_o !== 1'b1 || stall_mem_o !== 1'b0 || stall_fetch_o !== 1'b1) begin err++; $display("FAIL prio_store_done got=%b/%b/%b exp=1/0/1", dm_valid_o, stall_mem_o, stall_fetch_o); end
      dm_req_i = 1'b0; dm_we_i = 1'b0;
      @(negedge clk);
      vec++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h40) begin err++; $display("FAIL prio_fetch_second got=%b/%b/%h exp=1/0/00000040", mem_req_o, mem_we_o, mem_addr_o); end
      @(negedge clk);
      @(negedge clk);
      vec++; if (if_valid_o !== 1'b1 || if_rdata_o !== (32'h40 ^ KEY) || stall_fetch_o !== 1'b0) begin err++; $display("FAIL prio_fetch_done got=%b/%h/%b exp=1/%h/0", if_valid_o, if_rdata_o, stall_fetch_o, 32'h40 ^ KEY); end
      if_req_i = 1'b0;
      @(negedge clk);
   endtask

   task test_fairness();
      lat = 0;
      if_req_i = 1'b1; if_addr_i = 32'h80;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         if (t < 4) begin
            vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin err++; $display("FAIL fair_grant%0d got=%b/%h exp=1/00000300", t, mem_req_o, mem_addr_o); end
         end else begin
            vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h80) begin err++; $display("FAIL fair_forced_fetch got=%b/%h exp=1/00000080", mem_req_o, mem_addr_o); end
         end
         @(negedge clk);
         if (t < 4) begin
            vec++; if (dm_valid_o !== 1'b1 || if_valid_o !== 1'b0 || dm_rdata_o !== (32'h300 ^ KEY)) begin err++; $display("FAIL fair_load%0d got=%b/%b/%h exp=1/0/%h", t, dm_valid_o, if_valid_o, dm_rdata_o, 32'h300 ^ KEY); end
         end else begin
            vec++; if (if_valid_o !== 1'b1 || dm_valid_o !== 1'b0 || if_rdata_o !== (32'h80 ^ KEY)) begin err++; $display("FAIL fair_fetch_valid got=%b/%b/%h exp=1/0/%h", if_valid_o, dm_valid_o, if_rdata_o, 32'h80 ^ KEY); end
         end
      end
      // Counter cleared by the fetch grant: data wins again immediately.
      @(negedge clk);
      vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin err++; $display("FAIL fair_cnt_cleared got=%b/%h exp=1/00000300", mem_req_o, mem_addr_o); end
      @(negedge clk);
      dm_req_i = 1'b0; if_req_i = 1'b0;
      @(negedge clk);
   endtask

   task test_back_to_back();
      lat = 0;
      if_req_i = 1'b1; if_addr_i = 32'h100;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== (32'h100 + 32'(4 * k)) || if_valid_o !== 1'b0) begin err++; $display("FAIL b2b_req%0d got=%b/%h/%b exp=1/%h/0", k, mem_req_o, mem_addr_o, if_valid_o, 32'h100 + 32'(4 * k)); end
         @(negedge clk);
         vec++; if (if_valid_o !== 1'b1 || if_rdata_o !== ((32'h100 + 32'(4 * k)) ^ KEY)) begin err++; $display("FAIL b2b_valid%0d got=%b/%h exp=1/%h", k, if_valid_o, if_rdata_o, (32'h100 + 32'(4 * k)) ^ KEY); end
         if_addr_i = if_addr_i + 32'h4;
      end
      if_req_i = 1'b0;
      @(negedge clk);
   endtask

   task test_flush();
      lat = 3;
      if_req_i = 1'b1; if_addr_i = 32'h500;
      @(negedge clk);
      vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h500) begin err++; $display("FAIL flush_req got=%b/%h exp=1/00000500", mem_req_o, mem_addr_o); end
      if_flush_i = 1'b1; if_addr_i = 32'h600;
      #1;
      vec++; if (stall_fetch_o !== 1'b0) begin err++; $display("FAIL flush_stall got=%b exp=0", stall_fetch_o); end
      @(negedge clk);
      if_flush_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h500) begin err++; $display("FAIL flush_still_busy got=%b/%h exp=1/00000500", mem_req_o, mem_addr_o); end
      @(negedge clk);
      vec++; if (if_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin err++; $display("FAIL flush_suppressed got=%b/%b exp=0/0", if_valid_o, mem_req_o); end
      vec++; if (if_rdata_o !== (32'h10C ^ KEY)) begin err++; $display("FAIL flush_rdata_discard got=%h exp=%h", if_rdata_o, 32'h10C ^ KEY); end
      @(negedge clk);
      vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h600 || if_valid_o !== 1'b0) begin err++; $display("FAIL flush_new_addr got=%b/%h/%b exp=1/00000600/0", mem_req_o, mem_addr_o, if_valid_o); end
      repeat (4) @(negedge clk);
      vec++; if (if_valid_o !== 1'b1 || if_rdata_o !== (32'h600 ^ KEY)) begin err++; $display("FAIL flush_refetch got=%b/%h exp=1/%h", if_valid_o, if_rdata_o, 32'h600 ^ KEY); end
      if_req_i = 1'b0;
      @(negedge clk);
      // Flush while idle blocks the grant for that cycle only.
      lat = 0;
      if_req_i = 1'b1; if_flush_i = 1'b1; if_addr_i = 32'h900;
      @(negedge clk);
      vec++; if (mem_req_o !== 1'b0) begin err++; $display("FAIL flush_idle_block got=%b exp=0", mem_req_o); end
      if_flush_i = 1'b0;
      @(negedge clk);
      vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h900) begin err++; $display("FAIL flush_idle_release got=%b/%h exp=1/00000900", mem_req_o, mem_addr_o); end
      @(negedge clk);
      vec++; if (if_valid_o !== 1'b1) begin err++; $display("FAIL flush_idle_valid got=%b exp=1", if_valid_o); end
      if_req_i = 1'b0;
      @(negedge clk);
   endtask

   task test_reset_mid();
      model_en = 1'b0;
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h700; dm_wdata_i = 32'h55;
      @(negedge clk);
      vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h700) begin err++; $display("FAIL rmid_req got=%b/%h exp=1/00000700", mem_req_o, mem_addr_o); end
      reset = 1'b1;
      @(negedge clk);
      vec++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || dm_valid_o !== 1'b0 || if_valid_o !== 1'b0) begin err++; $display("FAIL rmid_dropped got=%b/%b/%b/%b exp=0/0/0/0", mem_req_o, mem_we_o, dm_valid_o, if_valid_o); end
      vec++; if (mem_addr_o !== 32'h0 || if_rdata_o !== 32'h0 || dm_rdata_o !== 32'h0) begin err++; $display("FAIL rmid_regs got=%h/%h/%h exp=0", mem_addr_o, if_rdata_o, dm_rdata_o); end
      reset = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0; ack_force = 1'b1;
      @(negedge clk);
      ack_force = 1'b0;
      vec++; if (dm_valid_o !== 1'b0 || if_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin err++; $display("FAIL rmid_late_ack got=%b/%b/%b exp=0/0/0", dm_valid_o, if_valid_o, mem_req_o); end
      @(negedge clk);
      vec++; if (dm_valid_o !== 1'b0 || mem_req_o !== 1'b0) begin err++; $display("FAIL rmid_idle got=%b/%b exp=0/0", dm_valid_o, mem_req_o); end
      model_en = 1'b1;
   endtask

   initial begin
      vec = 0; err = 0;
      lat = 0; model_en = 1'b1; ack_force = 1'b0;
      reset = 1'b1;
      if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = 32'h0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
      test_reset();
      test_fetch_only();
      test_priority();
      test_fairness();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
